// File: rtl/sfp_bit_packer_if.sv
// sfp_bit_packer_if: sfp result input and packed-word output handshake bundle
interface sfp_bit_packer_if #(
  parameter int psum_bw = 16,
  parameter int pack_w = 8
);
  localparam int lw = $clog2(pack_w + 1);
  logic signed [psum_bw-1:0] in;
  logic in_valid;
  logic in_ready;
  logic flush;
  logic [pack_w-1:0] out_word;
  logic [lw-1:0] out_len;
  logic out_valid;
  logic out_ready;
  logic busy;
  modport master(output in, in_valid, flush, out_ready, input in_ready, out_word, out_len, out_valid, busy);
  modport slave(input in, in_valid, flush, out_ready, output in_ready, out_word, out_len, out_valid, busy);
endinterface

// File: rtl/sfp_bit_packer.sv
// sfp_bit_packer: packs thresholded sfp results LSB-first into words buffered in a FWFT FIFO
module sfp_bit_packer #(
  parameter int psum_bw = 16,
  parameter int pack_w = 8,
  parameter int depth = 4
) (
  input logic clk,
  input logic reset,
  sfp_bit_packer_if.slave bus
);
  localparam int lw = $clog2(pack_w + 1);
  localparam int aw = $clog2(depth);
  typedef enum logic {ACC, FLUSH_PEND} state_t;
  state_t state;
  logic [lw-1:0] cnt, ncnt, push_len;
  logic [pack_w-1:0] shreg, nshreg;
  logic [pack_w-1:0] mem_w [depth];
  logic [lw-1:0] mem_l [depth];
  logic [aw-1:0] wr, rd;
  logic [aw:0] count;
  logic full, accept, pop, push, word_done, flush_now, go_pend;
  always_comb begin
    full = count == (aw+1)'(depth);
    bus.in_ready = !full && state == ACC;
    accept = bus.in_valid && bus.in_ready;
    nshreg = shreg | ((accept && bus.in != '0) ? pack_w'(1) << cnt : '0);
    ncnt = cnt + lw'(accept);
    word_done = accept && cnt == lw'(pack_w - 1);
    flush_now = state == ACC && bus.flush && !full && ncnt != '0 && !word_done;
    go_pend = state == ACC && bus.flush && full && cnt != '0;
    push = word_done || flush_now || (state == FLUSH_PEND && !full);
    push_len = word_done ? lw'(pack_w) : ncnt;
    pop = bus.out_valid && bus.out_ready;
  end
  assign bus.out_valid = count != '0;
  assign bus.out_word = bus.out_valid ? mem_w[rd] : '0;
  assign bus.out_len = bus.out_valid ? mem_l[rd] : '0;
  assign bus.busy = cnt != '0 || bus.out_valid || state == FLUSH_PEND;
  // a pending flush pushes shreg/cnt unchanged, since no accept can occur in FLUSH_PEND
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ACC;
      cnt <= '0;
      shreg <= '0;
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_w[wr] <= nshreg;
        mem_l[wr] <= push_len;
        wr <= wr + aw'(1);
      end
      if (pop) rd <= rd + aw'(1);
      count <= count + (aw+1)'(push) - (aw+1)'(pop);
      cnt <= push ? '0 : ncnt;
      shreg <= push ? '0 : nshreg;
      state <= go_pend ? FLUSH_PEND : (push ? ACC : state);
    end
  end
endmodule

// File: tb/tb_sfp_bit_packer.sv
// tb_sfp_bit_packer: directed and random checks of sfp_bit_packer against a queue-based model
module tb_sfp_bit_packer;
  localparam int PW = 8;
  localparam int DEPTH = 4;
  typedef struct {logic [7:0] w; logic [3:0] l;} ent_t;
  logic clk = 0;
  logic reset;
  int nerr = 0;
  int nchk = 0;
  int bq[$];
  ent_t fq[$];
  bit pend = 0;
  sfp_bit_packer_if #(.psum_bw(16), .pack_w(PW)) bus();
  sfp_bit_packer #(.psum_bw(16), .pack_w(PW), .depth(DEPTH)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t mk();
    ent_t e;
    e.w = '0;
    foreach (bq[i]) e.w[i] = bq[i][0];
    e.l = 4'(bq.size());
    bq.delete();
    return e;
  endfunction
  // Reference: pending result bits and queued words as plain queues
  function automatic void model_step(logic r, logic [15:0] d, logic v, logic f, logic o);
    int sz;
    bit rdy;
    if (!r) begin
      bq.delete();
      fq.delete();
      pend = 0;
      return;
    end
    sz = fq.size();
    rdy = sz < DEPTH && !pend;
    if (sz > 0 && o) void'(fq.pop_front());
    if (pend) begin
      if (sz < DEPTH) begin
        fq.push_back(mk());
        pend = 0;
      end
    end else begin
      if (v && rdy) bq.push_back(d != 0);
      if (bq.size() == PW) fq.push_back(mk());
      else if (f && bq.size() > 0) begin
        if (sz < DEPTH) fq.push_back(mk());
        else pend = 1;
      end
    end
  endfunction
  task automatic cyc(input logic r, input logic [15:0] d, input logic v, input logic f, input logic o);
    reset = r;
    bus.in = d;
    bus.in_valid = v;
    bus.flush = f;
    bus.out_ready = o;
    @(negedge clk);
    chk("out_valid", bus.out_valid, fq.size() != 0);
    chk("in_ready", bus.in_ready, fq.size() < DEPTH && !pend);
    chk("busy", bus.busy, bq.size() != 0 || fq.size() != 0 || pend);
    chk("out_word", bus.out_word, fq.size() != 0 ? fq[0].w : 8'h0);
    chk("out_len", bus.out_len, fq.size() != 0 ? fq[0].l : 4'h0);
    model_step(r, d, v, f, o);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] pat;
    reset = 0;
    bus.in = 16'h1;
    bus.in_valid = 1;
    bus.flush = 0;
    bus.out_ready = 0;
    @(posedge clk);
    #1;
    cyc(0, 16'h1, 1, 0, 0);
    cyc(0, 16'h1, 1, 0, 0);
    chk("t1_valid", bus.out_valid, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_ready", bus.in_ready, 1);
    pat = 8'h59;
    for (int i = 0; i < 8; i++) cyc(1, {15'h0, pat[i]}, 1, 0, 1);
    chk("t2_word", bus.out_word, 8'h59);
    chk("t2_len", bus.out_len, 8);
    chk("t2_valid", bus.out_valid, 1);
    cyc(1, 16'h0, 0, 0, 1);
    cyc(1, 16'hFFFF, 1, 0, 0);
    cyc(1, 16'h0000, 1, 0, 0);
    cyc(1, 16'h0002, 1, 0, 0);
    cyc(1, 16'h0, 0, 1, 0);
    chk("t3_word", bus.out_word, 8'h05);
    chk("t3_len", bus.out_len, 3);
    cyc(1, 16'h0, 0, 0, 1);
    cyc(1, 16'h0, 0, 1, 0);
    chk("t4_noempty", bus.out_valid, 0);
    for (int i = 0; i < 7; i++) cyc(1, 16'h8000, 1, 0, 0);
    cyc(1, 16'h8000, 1, 1, 0);
    chk("t4_word", bus.out_word, 8'hFF);
    chk("t4_len", bus.out_len, 8);
    cyc(1, 16'h0, 0, 0, 1);
    chk("t4_single", bus.out_valid, 0);
    for (int i = 0; i < 32; i++) cyc(1, 16'h1, 1, 0, 0);
    chk("t5_full", bus.in_ready, 0);
    cyc(1, 16'h1, 1, 0, 0);
    chk("t5_ignored", bus.busy && !bus.in_ready, 1);
    cyc(1, 16'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 16'h1, 1, 0, 0);
    cyc(1, 16'h0, 0, 1, 0);
    chk("t5_full2", bus.in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_order", {bus.out_len, bus.out_word}, i == 3 ? 12'h307 : 12'h8FF);
      cyc(1, 16'h0, 0, 0, 1);
    end
    for (int i = 0; i < 21; i++) cyc(1, 16'h1, 1, 0, 0);
    chk("t6_busy_pre", bus.busy, 1);
    cyc(0, 16'h1, 1, 1, 1);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy", bus.busy, 0);
    pat = 8'h03;
    for (int i = 0; i < 8; i++) cyc(1, {15'h0, pat[i]}, 1, 0, 0);
    chk("t6_word", bus.out_word, 8'h03);
    chk("t6_len", bus.out_len, 8);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(49) != 0, $urandom_range(1) != 0 ? 16'($urandom) : 16'h0,
          $urandom_range(9) < 7, $urandom_range(9) == 0, $urandom_range(1) != 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
